// File: rtl/cfg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cfg_pkg : shared types and constants for the column config serializer    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package cfg_pkg;

  localparam int CFG_WORD_W = 32;
  localparam int BIT_CNT_W  = 5;

  // Status register layout: {busy, 15'b0, last_col[7:0], word_cnt[7:0]}
  localparam int STAT_WCNT_LSB = 0;
  localparam int STAT_LCOL_LSB = 8;
  localparam int STAT_BUSY_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ACK   = 3'd3,
    ST_RACK  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cfg_piso.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cfg_piso : 32-bit parallel-load, shift-right register with bit counter   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cfg_piso
  import cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [CFG_WORD_W-1:0] i_din,
  output logic                  o_dout,
  output logic                  o_last
);

  logic [CFG_WORD_W-1:0] sr_q, sr_d;
  logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (i_load) begin
      sr_d  = i_din;
      cnt_d = '0;
    end else if (i_shift) begin
      sr_d  = {1'b0, sr_q[CFG_WORD_W-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_dout = sr_q[0];
  // Counter holds the index of the bit currently on o_dout.
  assign o_last = (cnt_q == '1);

endmodule
`default_nettype wire

// File: rtl/wb_cfg_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_cfg_serializer : Wishbone slave feeding per-column serial cfg chains  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module wb_cfg_serializer
  import cfg_pkg::*;
#(
  parameter int          MX            = 2,
  parameter int          WORDS_PER_COL = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter logic [31:0] STATUS_OFS    = 32'h100
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [MX-1:0] col_sel,
  output logic          cfg_out_start,
  output logic          cfg_bit_out,
  output logic          cfg_bit_out_valid
);

  state_e      state_q, state_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [7:0]  last_col_q, last_col_d;
  logic [31:0] rdata_q, rdata_d;

  logic          w_req, w_load, w_shift, w_sr_bit, w_last_bit;
  logic          w_wr_hit, w_stat_hit;
  logic [31:0]   w_offs, w_status;
  logic [7:0]    w_col;
  logic [MX-1:0] w_col_onehot;

  assign w_req      = wbs_stb_i & wbs_cyc_i;
  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
  assign w_offs     = wbs_adr_i - BASE_ADDR;
  assign w_col      = w_offs[9:2];
  assign w_wr_hit   = wbs_we_i && (wbs_sel_i == 4'hF) && (w_offs[1:0] == 2'b00)
                      && (w_offs < 32'(4 * MX));
  assign w_stat_hit = !wbs_we_i && (wbs_adr_i == BASE_ADDR + STATUS_OFS);

  always_comb begin
    w_status                           = '0;
    w_status[STAT_BUSY_BIT]            = (state_q != ST_IDLE);
    w_status[STAT_LCOL_LSB +: 8]       = last_col_q;
    w_status[STAT_WCNT_LSB +: 8]       = word_cnt_q;
  end

  always_comb begin
    w_col_onehot = '0;
    for (int i = 0; i < MX; i++) begin
      w_col_onehot[i] = (last_col_q == 8'(i));
    end
  end

  always_comb begin
    state_d           = state_q;
    word_cnt_d        = word_cnt_q;
    last_col_d        = last_col_q;
    rdata_d           = rdata_q;
    w_load            = 1'b0;
    w_shift           = 1'b0;
    wbs_ack_o         = 1'b0;
    wbs_dat_o         = '0;
    col_sel           = '0;
    cfg_out_start     = 1'b0;
    cfg_bit_out       = 1'b0;
    cfg_bit_out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          if (w_wr_hit) begin
            w_load     = 1'b1;
            last_col_d = w_col;
            if (w_col != last_col_q) word_cnt_d = '0;
            state_d    = ST_START;
          end else begin
            rdata_d = w_stat_hit ? w_status : '0;
            state_d = ST_RACK;
          end
        end
      end
      ST_START: begin
        col_sel       = w_col_onehot;
        cfg_out_start = (word_cnt_q == '0);
        state_d       = ST_SHIFT;
      end
      ST_SHIFT: begin
        col_sel           = w_col_onehot;
        cfg_bit_out       = w_sr_bit;
        cfg_bit_out_valid = 1'b1;
        w_shift           = 1'b1;
        if (w_last_bit) state_d = ST_ACK;
      end
      ST_ACK: begin
        col_sel    = w_col_onehot;
        wbs_ack_o  = 1'b1;
        word_cnt_d = (word_cnt_q == 8'(WORDS_PER_COL - 1)) ? '0 : word_cnt_q + 8'd1;
        state_d    = ST_IDLE;
      end
      ST_RACK: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = rdata_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      last_col_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      last_col_q <= last_col_d;
      rdata_q    <= rdata_d;
    end
  end

  cfg_piso u_piso (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (wbs_dat_i),
    .o_dout  (w_sr_bit),
    .o_last  (w_last_bit)
  );

endmodule
`default_nettype wire
